// File: rtl/output_port_arbiter_if.sv
// Output-port arbiter bus: input-buffer front flits in, forwarded flit out.
// Carries no state itself; timing is set by output_port_arbiter.
// Backpressure comes from down_on_i; read_o pops the granted buffer.
interface output_port_arbiter_if #(
    parameter int N_PORTS = 5,
    parameter int FLIT_W  = 32
);
    localparam int OW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0]        buf_empty_i;
    logic [N_PORTS*FLIT_W-1:0] flit_i;
    logic                      down_on_i;
    logic [N_PORTS-1:0]        read_o;
    logic [FLIT_W-1:0]         flit_o;
    logic                      flit_valid_o;
    logic [OW-1:0]             owner_o;
    logic                      busy_o;
    logic                      err_o;

    // Environment side: drives buffer state and downstream on/off.
    modport master (
        output buf_empty_i, flit_i, down_on_i,
        input  read_o, flit_o, flit_valid_o, owner_o, busy_o, err_o
    );

    // Arbiter side.
    modport slave (
        input  buf_empty_i, flit_i, down_on_i,
        output read_o, flit_o, flit_valid_o, owner_o, busy_o, err_o
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin wormhole arbiter granting one output port to N input buffers.
// Latency: read_o combinational, forwarded flit registered one cycle later.
// Backpressure: down_on_i=0 freezes grants and state; owner keeps the port.
module output_port_arbiter #(
    parameter int N_PORTS = 5,
    parameter int FLIT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output_port_arbiter_if.slave port_if
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int SW = PW + 1;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       owner;
    logic                busy;
    logic                err;
    logic [FLIT_W-1:0]   flit_out;
    logic                flit_valid;

    logic [FLIT_W-1:0]   flits [N_PORTS];
    logic [1:0]          ftype [N_PORTS];
    logic [N_PORTS-1:0]  eligible;
    logic [N_PORTS-1:0]  stray;
    logic                found;
    logic [PW-1:0]       winner;
    logic [SW-1:0]       sum;
    logic [N_PORTS-1:0]  grant;
    logic [FLIT_W-1:0]   sel_flit;
    logic [1:0]          sel_type;

    // Split the flat flit bus and classify each buffer's front flit.
    always_comb begin
        for (int k = 0; k < N_PORTS; k++) begin
            flits[k]    = port_if.flit_i[k*FLIT_W +: FLIT_W];
            ftype[k]    = flits[k][FLIT_W-1:FLIT_W-2];
            eligible[k] = !port_if.buf_empty_i[k] && (ftype[k] == T_HEAD || ftype[k] == T_HT);
            stray[k]    = !port_if.buf_empty_i[k] && (ftype[k] == T_BODY || ftype[k] == T_TAIL);
        end
    end

    // First eligible port scanning from rr_ptr, wrapping modulo N_PORTS.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(N_PORTS)) begin
                sum = sum - SW'(N_PORTS);
            end
            if (!found && eligible[sum[PW-1:0]]) begin
                found  = 1'b1;
                winner = sum[PW-1:0];
            end
        end
    end

    // Grant: new winner when idle, only the owner when locked, nothing in reset.
    always_comb begin
        grant    = '0;
        sel_flit = '0;
        if (!rst && port_if.down_on_i) begin
            if (state == IDLE) begin
                if (found) begin
                    grant[winner] = 1'b1;
                    sel_flit      = flits[winner];
                end
            end else begin
                if (!port_if.buf_empty_i[owner]) begin
                    grant[owner] = 1'b1;
                    sel_flit     = flits[owner];
                end
            end
        end
        sel_type = sel_flit[FLIT_W-1:FLIT_W-2];
    end

    // Packet-lock FSM with registered forwarding path and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
        end else begin
            flit_valid <= |grant;
            if (|grant) begin
                flit_out <= sel_flit;
            end
            if (port_if.down_on_i) begin
                case (state)
                    IDLE: begin
                        // A body/tail at a buffer front with no open packet is orphaned.
                        if (|stray) begin
                            err <= 1'b1;
                        end
                        if (found) begin
                            rr_ptr <= (winner == PW'(N_PORTS - 1)) ? '0 : winner + 1'b1;
                            if (sel_type == T_HEAD) begin
                                state <= LOCKED;
                                owner <= winner;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!port_if.buf_empty_i[owner]) begin
                            if (sel_type == T_TAIL) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else if (sel_type != T_BODY) begin
                                // Stray head inside a packet: flag it but keep the lock.
                                err <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign port_if.read_o       = grant;
    assign port_if.flit_o       = flit_out;
    assign port_if.flit_valid_o = flit_valid;
    assign port_if.owner_o      = owner;
    assign port_if.busy_o       = busy;
    assign port_if.err_o        = err;

endmodule
